// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle for apb_slave_mem.
// APB_SLAVE_MEM_PSLVERR_EN adds the PSLVERR response signal.
interface apb_slave_mem_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef APB_SLAVE_MEM_PSLVERR_EN
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
`else
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
`endif
endinterface

// File: rtl/apb_slave_mem.sv
// APB slave word memory with a fixed number of wait states per access.
// Optional feature macro: APB_SLAVE_MEM_PSLVERR_EN (PSLVERR on out-of-range access).
module apb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          CLK,
  input  logic          PRESET,
  apb_slave_mem_if.slave apb
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                in_range_q, in_range_d;
  logic                pready_q, pready_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
`ifdef APB_SLAVE_MEM_PSLVERR_EN
  logic                pslverr_q, pslverr_d;
`endif

  logic                in_range_c;
  logic [IDX_W-1:0]    idx_c;

  // Decode the live bus address into a range flag and word index.
  always_comb begin
    in_range_c = ({1'b0, apb.PADDR} >= {1'b0, BASE_ADDR}) &&
                 ({1'b0, apb.PADDR} < ({1'b0, BASE_ADDR} + 33'(4 * DEPTH)));
    idx_c      = IDX_W'((apb.PADDR - BASE_ADDR) >> 2);
  end

  // Next-state, memory update and registered response computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    mem_d      = mem_q;

    case (state_q)
      S_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          write_d    = apb.PWRITE;
          idx_d      = idx_c;
          in_range_d = in_range_c;
          if (WAIT_STATES == 0) begin
            state_d = S_READY;
          end else begin
            cnt_d   = CNT_W'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!apb.PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READY: begin
        // Completion or abort both return to IDLE; only a completed in-range write commits.
        state_d = S_IDLE;
        if (apb.PSEL && apb.PENABLE && write_q && in_range_q) begin
          mem_d[idx_q] = apb.PWDATA;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // READY is never held for more than one cycle, so PRDATA is loaded on entry
    // and naturally cleared on the edge that leaves it.
    pready_d = (state_d == S_READY);
    prdata_d = (state_d == S_READY && !write_d && in_range_d) ? mem_q[idx_d] : '0;
`ifdef APB_SLAVE_MEM_PSLVERR_EN
    pslverr_d = (state_d == S_READY) && !in_range_d;
`endif
  end

  // State, latched transfer attributes, response and memory registers.
  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
`ifdef APB_SLAVE_MEM_PSLVERR_EN
      pslverr_q  <= 1'b0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
`ifdef APB_SLAVE_MEM_PSLVERR_EN
      pslverr_q  <= pslverr_d;
`endif
      mem_q      <= mem_d;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PRDATA  = prdata_q;
`ifdef APB_SLAVE_MEM_PSLVERR_EN
  assign apb.PSLVERR = pslverr_q;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: driver pushes expected responses,
// a negedge monitor pops and compares whenever PREADY is presented.
module tb_apb_slave_mem;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WS    = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  logic PRESET;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] model [DEPTH];
  exp_t exp_q[$];
  logic prev_ready = 1'b0;

  always #5 CLK = ~CLK;

  apb_slave_mem_if bus ();

  apb_slave_mem #(
    .BASE_ADDR  (BASE),
    .DEPTH      (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .CLK   (CLK),
    .PRESET(PRESET),
    .apb   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [63:0] a64, lo, hi;
    a64 = {32'd0, a};
    lo  = {32'd0, BASE};
    hi  = lo + 64'(4 * DEPTH);
    return (a64 >= lo) && (a64 < hi);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Monitor: every PREADY cycle must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (PRESET !== 1'b0) begin
      prev_ready <= 1'b0;
    end else begin
      if (bus.PREADY === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 32'(bus.PREADY), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("prdata", bus.PRDATA, e.rdata);
`ifdef APB_SLAVE_MEM_PSLVERR_EN
          check("pslverr", 32'(bus.PSLVERR), 32'(e.err));
`endif
        end
      end else if (prev_ready) begin
        check("prdata_clear", bus.PRDATA, 32'd0);
      end
      prev_ready <= bus.PREADY;
    end
  end

  // One complete transfer; leaves PSEL high so the next call is back-to-back.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    bit   ok;
    int   waits;
    ok      = in_rng(addr);
    e.err   = !ok;
    e.rdata = (!wr && ok) ? model[word_of(addr)] : 32'd0;
    exp_q.push_back(e);
    if (wr && ok) model[word_of(addr)] = data;

    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = $urandom;
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    bus.PADDR   = $urandom;
    bus.PWRITE  = 1'($urandom);
    bus.PWDATA  = data;
    waits = 0;
    while (bus.PREADY !== 1'b1 && waits < 20) begin
      @(posedge CLK); #1;
      waits++;
    end
    check("latency", 32'(waits), 32'(WS));
    @(posedge CLK); #1;
  endtask

  task automatic go_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    int wd;
    PRESET      = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_pready", 32'(bus.PREADY), 32'd0);
    check("reset_prdata", bus.PRDATA, 32'd0);
    PRESET = 1'b0;
    @(posedge CLK); #1;

    // Basic write then read-back.
    xfer(1'b1, BASE + 32'd8, 32'hDEAD_BEEF);
    xfer(1'b0, BASE + 32'd8, 32'd0);
    xfer(1'b1, BASE + 32'd4, 32'h1234_5678);
    xfer(1'b0, BASE + 32'd4, 32'd0);
    go_idle();

    // Back-to-back fill then read with low address bits ignored.
    for (int i = 0; i < int'(DEPTH); i++) xfer(1'b1, BASE + 32'(4 * i), 32'(i));
    for (int i = 0; i < int'(DEPTH); i++) xfer(1'b0, BASE + 32'(4 * i + (i % 4)), 32'd0);
    go_idle();

    // Out-of-range accesses on both sides of the window.
    xfer(1'b1, BASE + 32'(4 * DEPTH), 32'hCAFE_F00D);
    xfer(1'b0, BASE + 32'(4 * DEPTH), 32'd0);
    xfer(1'b0, BASE, 32'd0);
    xfer(1'b1, BASE - 32'd4, 32'h5555_AAAA);
    xfer(1'b0, BASE - 32'd4, 32'd0);
    xfer(1'b0, BASE + 32'(4 * DEPTH - 4), 32'd0);
    go_idle();

    // Write aborted during the wait phase must not commit.
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = BASE + 32'd12;
    bus.PWDATA  = 32'hBAD0_BAD0;
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge CLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      check("abort_no_pready", 32'(bus.PREADY), 32'd0);
    end
    xfer(1'b0, BASE + 32'd12, 32'd0);
    go_idle();

    // PENABLE without a setup phase is ignored.
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = BASE;
    bus.PWDATA  = 32'hFFFF_FFFF;
    repeat (4) begin
      @(posedge CLK); #1;
      check("no_setup_ignored", 32'(bus.PREADY), 32'd0);
    end
    xfer(1'b0, BASE, 32'd0);
    go_idle();

    // Randomized traffic, with occasional idle gaps.
    for (int n = 0; n < 60; n++) begin
      xfer(1'($urandom), BASE - 32'd16 + 32'($urandom_range(0, 4 * DEPTH + 32)), $urandom);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    // Reset while a write to word 5 sits in READY: nothing commits, memory clears.
    xfer(1'b1, BASE + 32'd20, 32'hA5A5_0005);
    go_idle();
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = BASE + 32'd20;
    bus.PWDATA  = 32'h7777_7777;
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    wd = 0;
    while (bus.PREADY !== 1'b1 && wd < 20) begin
      @(posedge CLK); #1;
      wd++;
    end
    check("reset_test_reach_ready", 32'(bus.PREADY), 32'd1);
    PRESET = 1'b1;
    #1;
    check("midreset_pready", 32'(bus.PREADY), 32'd0);
    check("midreset_prdata", bus.PRDATA, 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    PRESET = 1'b0;
    @(posedge CLK); #1;
    xfer(1'b0, BASE + 32'd20, 32'd0);
    xfer(1'b0, BASE + 32'd8, 32'd0);
    go_idle();

    // Drain outstanding expectations with a bounded wait.
    wd = 0;
    while (exp_q.size() != 0 && wd < 50) begin
      @(posedge CLK); #1;
      wd++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB slave memory that sits directly downstream of the AHB2APB bridge APB master port.
- Consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA/PREADY.
- Provides a word-addressed register bank with a fixed, parameterised wait-state count.
- Serves as the DUT-side completer for bridge read/write traffic and as the scoreboard's reference target.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH, 16, number of 32-bit words; power of two, 2..1024.
- WAIT_STATES, 0, PREADY-low cycles inserted in each access phase; range 0..15.

Ports:
- CLK  input  1  APB clock; all state updates on the rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, valid while PREADY=1 on a read.
- PREADY  output  1  transfer-complete indication, registered.

Behaviour:
- Reset (PRESET=1, asynchronous): state=IDLE, PREADY=0, PRDATA=0, wait counter=0, all DEPTH words cleared to 0.
- Address decode: in_range = (PADDR >= BASE_ADDR) && (PADDR < BASE_ADDR + 4*DEPTH).
- Word index = (PADDR - BASE_ADDR) >> 2, truncated to clog2(DEPTH) bits; PADDR[1:0] is ignored.
- FSM states:
  - IDLE: PREADY=0. On an edge with PSEL=1 and PENABLE=0 (setup phase), latch PWRITE and the index.
    - If WAIT_STATES==0, go to READY.
    - Otherwise load cnt = WAIT_STATES-1 and go to WAIT.
    - PENABLE=1 without a preceding setup phase is ignored; stay in IDLE.
  - WAIT: PREADY=0.
    - If PSEL=0, abort and go to IDLE; no write occurs.
    - Else if cnt==0, go to READY.
    - Else decrement cnt.
  - READY: PREADY=1.
    - On an edge with PSEL=1 and PENABLE=1, the transfer completes: a write in range commits PWDATA to the word; go to IDLE.
    - If PSEL=0 or PENABLE=0 in READY, abort to IDLE with no write.
- Latency: the access phase lasts exactly WAIT_STATES+1 cycles. Zero-wait transfer: setup at cycle 0, PREADY=1 at cycle 1, done at the end of cycle 1.
- PRDATA is loaded on the edge entering READY:
  - read in range: memory word;
  - read out of range, or any write: 0.
  - PRDATA is cleared to 0 on the edge leaving READY.
- Back-to-back: the cycle after completion may be a new setup phase (PSEL stays 1, PENABLE=0). IDLE accepts it with no bubble.
- Out-of-range write: dropped, memory unchanged, completes normally.
- Read-after-write to the same word in the next transfer returns the new data.
- Address and direction are latched at setup. Changes to PADDR/PWRITE during the access phase are ignored. PWDATA is sampled at the completion edge.
- Reset asserted mid-transfer: immediate return to IDLE with PREADY=0. An uncompleted write is never committed.

Optional Feature:
- Macro: APB_SLAVE_MEM_PSLVERR_EN.
- Defined:
  - Adds output port PSLVERR (1 bit), reset 0.
  - PSLVERR=1 exactly in READY when the latched address is out of range; 0 otherwise.
  - Error reads still return PRDATA=0; error writes are still dropped.
- Undefined: no PSLVERR port; out-of-range accesses complete silently as above.

Test Plan:
- Reset, then zero-wait write 32'hDEAD_BEEF to BASE_ADDR+8, then read it -> PREADY high in the cycle after each setup; read returns PRDATA=32'hDEAD_BEEF with PREADY=1.
- WAIT_STATES=3, read BASE_ADDR+4 after writing 32'h1234_5678 -> PREADY low for 3 access cycles, high on the 4th with PRDATA=32'h1234_5678; PRDATA=0 the following cycle.
- Back-to-back writes to words 0..15 with data = index, then 16 reads -> each read returns its index; no idle cycles needed between transfers.
- Write to BASE_ADDR+4*DEPTH (out of range), then read the same address and word 0 -> memory unchanged, reads return 0; with APB_SLAVE_MEM_PSLVERR_EN, PSLVERR=1 with PREADY for both out-of-range transfers and 0 for the word-0 read.
- WAIT_STATES=2, write setup to word 3, drop PSEL during WAIT -> FSM returns to IDLE, PREADY never asserts, later read of word 3 returns its old value.
- Assert PRESET mid-access on a write to word 5 -> PREADY=0 and PRDATA=0 immediately; word 5 reads 0 after reset releases.
